// File: rtl/vm_counter_pkg.sv
// Shared constants for the vending-machine counter family.
// Mode and direction encodings used by counters and step calculators.
package vm_counter_pkg;

  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/range_step_calc.sv
// Combinational next-value calculator for a bounded up/down step.
// Wraps or clamps inside [MIN_VAL..MAX_VAL] and flags crossings.
module range_step_calc
  import vm_counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 2,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  input  logic              mode,
  output logic [WIDTH-1:0]  nxt,
  output logic              ovf,
  output logic              unf
);

  localparam int EW =
    ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 2;

  localparam logic [EW-1:0] MIN_E = EW'(MIN_VAL);
  localparam logic [EW-1:0] MAX_E = EW'(MAX_VAL);
  localparam logic [EW-1:0] RNG_E =
    EW'(MAX_VAL - MIN_VAL + 1);

  logic [EW-1:0] cnt_e;
  logic [EW-1:0] stp_e;
  logic [EW-1:0] s_e;
  logic [EW-1:0] raw_up;
  logic [EW-1:0] nxt_e;

  // Limit the step to one full range, then wrap or clamp.
  always_comb begin
    cnt_e  = EW'(count);
    stp_e  = EW'(step);
    s_e    = (stp_e > RNG_E) ? RNG_E : stp_e;
    raw_up = cnt_e + s_e;
    nxt_e  = cnt_e;
    ovf    = 1'b0;
    unf    = 1'b0;
    if (dir == DIR_UP) begin
      if (raw_up > MAX_E) begin
        ovf   = 1'b1;
        nxt_e = (mode == CNT_SAT) ? MAX_E
                                  : raw_up - RNG_E;
      end else begin
        nxt_e = raw_up;
      end
    end else begin
      if (cnt_e < MIN_E + s_e) begin
        unf   = 1'b1;
        nxt_e = (mode == CNT_SAT) ? MIN_E
                                  : cnt_e + RNG_E - s_e;
      end else begin
        nxt_e = cnt_e - s_e;
      end
    end
    nxt = WIDTH'(nxt_e);
  end

endmodule

// File: rtl/updown_step_counter.sv
// Bounded up/down step counter with load, wrap/saturate
// and boundary flags for the vending-machine datapath.
module updown_step_counter
  import vm_counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP_W    = 2,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              at_max,
  output logic              at_min,
  output logic              ovf,
  output logic              unf
);

  generate
    if (MIN_VAL >= MAX_VAL) begin : g_bad_range
      $error("updown_step_counter: MIN_VAL >= MAX_VAL");
    end
    if (MIN_VAL < 0) begin : g_bad_min
      $error("updown_step_counter: MIN_VAL negative");
    end
    if (RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL)
    begin : g_bad_rst
      $error("updown_step_counter: RESET_VAL out of range");
    end
    if (longint'(MAX_VAL) >= (longint'(1) << WIDTH))
    begin : g_bad_max
      $error("updown_step_counter: MAX_VAL too wide");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);
  localparam logic MODE_C =
    (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] calc_nxt;
  logic             calc_ovf;
  logic             calc_unf;
  logic [WIDTH-1:0] load_clamp;

  range_step_calc #(
    .WIDTH   (WIDTH),
    .STEP_W  (STEP_W),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_calc (
    .count (count_q),
    .step  (step),
    .dir   (up_down),
    .mode  (MODE_C),
    .nxt   (calc_nxt),
    .ovf   (calc_ovf),
    .unf   (calc_unf)
  );

  // Load value forced into the legal range.
  always_comb begin
    load_clamp = load_val;
    if (load_val < MIN_C) begin
      load_clamp = MIN_C;
    end else if (load_val > MAX_C) begin
      load_clamp = MAX_C;
    end
  end

  // Next state: load beats count enable beats hold.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (load) begin
      count_d = load_clamp;
    end else if (en) begin
      count_d = calc_nxt;
      ovf_d   = calc_ovf;
      unf_d   = calc_unf;
    end
  end

  // Count and crossing-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_C;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count  = count_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign at_max = (count_q == MAX_C);
  assign at_min = (count_q == MIN_C);

endmodule

// File: tb/tb_updown_step_counter.sv
// Directed bench for updown_step_counter: wrap and
// saturate instances driven side by side.
module tb_updown_step_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up_down;
  logic [1:0] step;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] cw, cs;
  logic       mxw, mxs, mnw, mns;
  logic       ow, os, uw, us;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_step_counter #(
    .WIDTH(4), .STEP_W(2), .MIN_VAL(2), .MAX_VAL(12),
    .RESET_VAL(2), .SATURATE(0)
  ) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down),
    .step(step), .load(load), .load_val(load_val),
    .count(cw), .at_max(mxw), .at_min(mnw),
    .ovf(ow), .unf(uw)
  );

  updown_step_counter #(
    .WIDTH(4), .STEP_W(2), .MIN_VAL(2), .MAX_VAL(12),
    .RESET_VAL(2), .SATURATE(1)
  ) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down),
    .step(step), .load(load), .load_val(load_val),
    .count(cs), .at_max(mxs), .at_min(mns),
    .ovf(os), .unf(us)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; load = 1'b0; step = 2'd0;
    up_down = 1'b0; load_val = 4'd0;
  endtask

  task automatic preload(input logic [3:0] v);
    idle();
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #12;
    checks++;
    if (cw !== 4'd2 || cs !== 4'd2) begin
      errors++;
      $display("FAIL por_count: got %0d/%0d exp 2", cw, cs);
    end
    @(negedge clk);
    rst = 1'b0;
    preload(4'd7);
    checks++;
    if (cw !== 4'd7) begin
      errors++;
      $display("FAIL rst_pre7: got %0d exp 7", cw);
    end
    // Async assertion between edges, with load and en active.
    @(negedge clk);
    load = 1'b1; load_val = 4'd9; en = 1'b1; step = 2'd3;
    rst = 1'b1;
    #1;
    checks++;
    if (cw !== 4'd2 || cs !== 4'd2) begin
      errors++;
      $display("FAIL rst_async: got %0d/%0d exp 2", cw, cs);
    end
    checks++;
    if (ow !== 1'b0 || uw !== 1'b0 || mnw !== 1'b1
        || mxw !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: ovf %b unf %b min %b max %b exp 0 0 1 0",
               ow, uw, mnw, mxw);
    end
    tick();
    checks++;
    if (cw !== 4'd2) begin
      errors++;
      $display("FAIL rst_hold: got %0d exp 2", cw);
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_wrap_up();
    preload(4'd11);
    en = 1'b1; up_down = 1'b0; step = 2'd3;
    tick();
    checks++;
    if (cw !== 4'd3 || ow !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up: cnt %0d ovf %b exp 3 1", cw, ow);
    end
    checks++;
    if (cs !== 4'd12 || os !== 1'b1 || mxs !== 1'b1) begin
      errors++;
      $display("FAIL sat_up: cnt %0d ovf %b max %b exp 12 1 1",
               cs, os, mxs);
    end
    en = 1'b0;
    tick();
    checks++;
    if (cw !== 4'd3 || ow !== 1'b0 || os !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pulse: cnt %0d ovf %b/%b exp 3 0/0",
               cw, ow, os);
    end
  endtask

  task automatic test_sat_down();
    preload(4'd3);
    en = 1'b1; up_down = 1'b1; step = 2'd2;
    tick();
    checks++;
    if (cs !== 4'd2 || us !== 1'b1) begin
      errors++;
      $display("FAIL sat_dn1: cnt %0d unf %b exp 2 1", cs, us);
    end
    checks++;
    if (cw !== 4'd12 || uw !== 1'b1) begin
      errors++;
      $display("FAIL wrap_dn1: cnt %0d unf %b exp 12 1", cw, uw);
    end
    tick();
    checks++;
    if (cs !== 4'd2 || us !== 1'b1 || mns !== 1'b1) begin
      errors++;
      $display("FAIL sat_dn2: cnt %0d unf %b min %b exp 2 1 1",
               cs, us, mns);
    end
    checks++;
    if (cw !== 4'd10 || uw !== 1'b0) begin
      errors++;
      $display("FAIL wrap_dn2: cnt %0d unf %b exp 10 0", cw, uw);
    end
    idle();
    tick();
  endtask

  task automatic test_load_clamp();
    preload(4'd15);
    checks++;
    if (cw !== 4'd12 || cs !== 4'd12 || mxw !== 1'b1
        || ow !== 1'b0) begin
      errors++;
      $display("FAIL load_hi: cnt %0d/%0d max %b ovf %b exp 12 1 0",
               cw, cs, mxw, ow);
    end
    preload(4'd0);
    checks++;
    if (cw !== 4'd2 || cs !== 4'd2 || uw !== 1'b0
        || mnw !== 1'b1) begin
      errors++;
      $display("FAIL load_lo: cnt %0d/%0d unf %b min %b exp 2 0 1",
               cw, cs, uw, mnw);
    end
  endtask

  task automatic test_simultaneous();
    preload(4'd5);
    load = 1'b1; load_val = 4'd9;
    en = 1'b1; up_down = 1'b0; step = 2'd3;
    tick();
    checks++;
    if (cw !== 4'd9 || cs !== 4'd9 || ow !== 1'b0
        || uw !== 1'b0) begin
      errors++;
      $display("FAIL load_wins: cnt %0d/%0d ovf %b unf %b exp 9 0 0",
               cw, cs, ow, uw);
    end
    idle();
  endtask

  task automatic test_hold();
    preload(4'd12);
    en = 1'b1; up_down = 1'b0; step = 2'd0;
    tick();
    checks++;
    if (cw !== 4'd12 || cs !== 4'd12 || ow !== 1'b0
        || os !== 1'b0) begin
      errors++;
      $display("FAIL hold_s0: cnt %0d/%0d ovf %b/%b exp 12 0",
               cw, cs, ow, os);
    end
    en = 1'b0; step = 2'd3;
    tick();
    checks++;
    if (cw !== 4'd12 || cs !== 4'd12 || ow !== 1'b0) begin
      errors++;
      $display("FAIL hold_en0: cnt %0d/%0d ovf %b exp 12 0",
               cw, cs, ow);
    end
  endtask

  task automatic test_boundaries();
    preload(4'd9);
    en = 1'b1; up_down = 1'b0; step = 2'd3;
    tick();
    checks++;
    if (cw !== 4'd12 || ow !== 1'b0 || os !== 1'b0) begin
      errors++;
      $display("FAIL exact_max: cnt %0d ovf %b/%b exp 12 0",
               cw, ow, os);
    end
    preload(4'd2);
    en = 1'b1; up_down = 1'b1; step = 2'd3;
    tick();
    checks++;
    if (cw !== 4'd10 || uw !== 1'b1 || cs !== 4'd2
        || us !== 1'b1) begin
      errors++;
      $display("FAIL min_dn3: cnt %0d/%0d unf %b/%b exp 10/2 1/1",
               cw, cs, uw, us);
    end
    preload(4'd4);
    en = 1'b1; up_down = 1'b1; step = 2'd2;
    tick();
    checks++;
    if (cw !== 4'd2 || uw !== 1'b0 || mnw !== 1'b1) begin
      errors++;
      $display("FAIL exact_min: cnt %0d unf %b min %b exp 2 0 1",
               cw, uw, mnw);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    preload(4'd12);
    en = 1'b1; up_down = 1'b0; step = 2'd1;
    tick();
    checks++;
    if (cw !== 4'd2 || ow !== 1'b1 || cs !== 4'd12
        || os !== 1'b1) begin
      errors++;
      $display("FAIL b2b_1: cnt %0d/%0d ovf %b/%b exp 2/12 1/1",
               cw, cs, ow, os);
    end
    tick();
    checks++;
    if (cw !== 4'd3 || ow !== 1'b0 || cs !== 4'd12
        || os !== 1'b1) begin
      errors++;
      $display("FAIL b2b_2: cnt %0d/%0d ovf %b/%b exp 3/12 0/1",
               cw, cs, ow, os);
    end
    load = 1'b1; load_val = 4'd6;
    tick();
    checks++;
    if (cs !== 4'd6 || os !== 1'b0 || cw !== 4'd6) begin
      errors++;
      $display("FAIL b2b_load: cnt %0d/%0d ovf %b exp 6 0",
               cw, cs, os);
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_clamp();
    test_simultaneous();
    test_hold();
    test_boundaries();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_step_counter.md
Name: updown_step_counter

Overview:
Parametrised next-generation up/down counter for the vending-machine datapath, used for credit, coin and stock tallies. It adds a runtime step size, a bounded range [MIN_VAL..MAX_VAL], a synchronous load, and selectable wrap or saturate behaviour. It also provides boundary status flags and one-cycle overflow/underflow pulses for the controller FSM.

Parameters:
WIDTH, 8, counter width in bits
STEP_W, 2, width of the runtime step input
MIN_VAL, 0, lowest legal count value
MAX_VAL, 2**WIDTH-1, highest legal count value; MIN_VAL < MAX_VAL required
RESET_VAL, 0, count value after reset; must lie within [MIN_VAL..MAX_VAL]
SATURATE, 0, 0 = wrap within range, 1 = clamp at the bounds

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
en  input  1  count enable
up_down  input  1  direction: 0 = up, 1 = down
step  input  STEP_W  step magnitude; 0 = hold
load  input  1  synchronous load request
load_val  input  WIDTH  value to load
count  output  WIDTH  current count (registered)
at_max  output  1  count == MAX_VAL
at_min  output  1  count == MIN_VAL
ovf  output  1  one-cycle pulse: an up step crossed MAX_VAL
unf  output  1  one-cycle pulse: a down step crossed MIN_VAL

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values: count = RESET_VAL immediately on rst, regardless of clk; ovf = 0, unf = 0. at_max/at_min follow from count.
- Rst asserted mid-operation overrides any load or en in progress. The first update after release happens on the first clk edge with rst low.
- Priority per edge: load > en > hold.
- load: count <= load_val, clamped into [MIN_VAL..MAX_VAL] in both modes. ovf and unf stay 0.
- en = 1 and load = 0: R = MAX_VAL - MIN_VAL + 1; s = min(step, R).
- All arithmetic is done at WIDTH+2 bits, unsigned. Intermediate values never truncate.
- Up, raw = count + s:
  - raw <= MAX_VAL: count <= raw.
  - raw > MAX_VAL: ovf pulses 1. Wrap mode gives count <= raw - R. Saturate mode gives count <= MAX_VAL.
- Down, raw = count - s:
  - raw >= MIN_VAL: count <= raw.
  - raw < MIN_VAL: unf pulses 1. Wrap mode gives count <= raw + R. Saturate mode gives count <= MIN_VAL.
- Saturated hold at a bound counts as a crossing. At MAX_VAL, up with s > 0 pulses ovf every enabled cycle; at MIN_VAL, down with s > 0 pulses unf every enabled cycle.
- step = 0 with en = 1: count holds; ovf = unf = 0.
- ovf and unf are registered. They assert in the same cycle as the updated count, last exactly one cycle per offending step, and return to 0 on any non-crossing cycle, load, or idle.
- at_max and at_min are combinational compares of the count register, so they add no extra latency.
- Count-update latency: 1 clk from en/load to count.
- Illegal parameter combinations (MIN_VAL >= MAX_VAL, RESET_VAL out of range, MAX_VAL >= 2**WIDTH) are rejected by an elaboration-time check.

Decomposition:
- Shared package vm_counter_pkg:
  - mode constants CNT_WRAP = 0 and CNT_SAT = 1
  - direction constants DIR_UP = 0 and DIR_DOWN = 1
- One combinational sub-module, range_step_calc. It takes count, step, direction and mode, and returns the next value plus ovf/unf. It is reused by the channelised coin counter.
- The top level holds the register, load clamp and priority logic.

Test Plan (WIDTH=4, STEP_W=2, MIN_VAL=2, MAX_VAL=12, RESET_VAL=2):
1. Reset: count at 7, assert rst between clock edges -> count=2 immediately; ovf=0, unf=0, at_min=1.
2. Wrap up (SATURATE=0): count=11, en=1, up, step=3 -> count=3 next cycle; ovf=1 for that cycle only, then 0.
3. Saturate down (SATURATE=1): count=3, down, step=2 for two cycles -> count=2 then 2; unf=1 both cycles; at_min=1.
4. Load clamp: load=1, load_val=15 -> count=12, at_max=1, ovf=0. Then load_val=0 -> count=2, unf=0.
5. Simultaneous: count=5, load=1, load_val=9, en=1, up, step=3 -> count=9 (load wins), no flags.
6. Hold cases: en=1, step=0 at count=12 -> count stays 12, ovf=0. Then en=0, step=3 -> count stays 12.
